// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned 8x8 multiply / 8/8 divide sequencer. It borrows the core's
// 8-bit ALU for one add or subtract per clock: shift-add multiply, restoring divide.
module alu_muldiv_seq #(
   parameter int ITERS = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       is_div,
   input  logic [7:0] op_a,
   input  logic [7:0] op_b,
   output logic       busy,
   output logic       done,
   output logic [7:0] result_lo,
   output logic [7:0] result_hi,
   output logic       div_by_zero,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_op,
   output logic       alu_mode,
   output logic       alu_cf_in,
   input  logic [7:0] alu_res,
   input  logic       alu_cf
);

   localparam int CNT_W = $clog2(ITERS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_is_div;
   logic [7:0]       r_d;
   logic [7:0]       r_h;      // MUL: product high byte H; DIV: partial remainder R
   logic [7:0]       r_l;      // MUL: product low byte L;  DIV: quotient Q
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [7:0]       r_result_lo;
   logic [7:0]       r_result_hi;
   logic             r_dbz;

   logic [7:0]       w_s;
   logic [7:0]       w_h_nxt;
   logic [7:0]       w_l_nxt;

   assign w_s = {r_h[6:0], r_l[7]};

   // ALU drive depends only on registered state, so there is no loop through the ALU.
   always_comb begin
      alu_a     = 8'h00;
      alu_b     = 8'h00;
      alu_op    = 4'b1111;
      alu_mode  = 1'b1;
      alu_cf_in = 1'b0;
      if (r_state == S_ITER) begin
         alu_mode = 1'b0;
         if (r_is_div) begin
            alu_op    = 4'b0110;
            alu_cf_in = 1'b0;
            alu_a     = w_s;
            alu_b     = r_d;
         end else begin
            alu_op    = 4'b1001;
            alu_cf_in = 1'b1;
            alu_a     = r_h;
            alu_b     = r_l[0] ? r_d : 8'h00;
         end
      end
   end

   // One iteration step. A set R[7] means the true 9-bit partial remainder exceeds D.
   always_comb begin
      w_h_nxt = r_h;
      w_l_nxt = r_l;
      if (r_is_div) begin
         if (r_h[7] || !alu_cf) begin
            w_h_nxt = alu_res;
            w_l_nxt = {r_l[6:0], 1'b1};
         end else begin
            w_h_nxt = w_s;
            w_l_nxt = {r_l[6:0], 1'b0};
         end
      end else begin
         {w_h_nxt, w_l_nxt} = {~alu_cf, alu_res, r_l[7:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_is_div    <= 1'b0;
         r_d         <= 8'h00;
         r_h         <= 8'h00;
         r_l         <= 8'h00;
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_result_lo <= 8'h00;
         r_result_hi <= 8'h00;
         r_dbz       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_is_div <= is_div;
                  r_d      <= op_b;
                  r_h      <= 8'h00;
                  r_l      <= op_a;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_dbz    <= 1'b0;
                  if (is_div && (op_b == 8'h00)) begin
                     r_state     <= S_DONE;
                     r_done      <= 1'b1;
                     r_result_lo <= 8'hFF;
                     r_result_hi <= op_a;
                     r_dbz       <= 1'b1;
                  end else begin
                     r_state <= S_ITER;
                  end
               end
            end
            S_ITER: begin
               r_h   <= w_h_nxt;
               r_l   <= w_l_nxt;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_state     <= S_DONE;
                  r_done      <= 1'b1;
                  r_result_hi <= w_h_nxt;
                  r_result_lo <= w_l_nxt;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign result_lo   = r_result_lo;
   assign result_hi   = r_result_hi;
   assign div_by_zero = r_dbz;

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle unsigned 8x8 multiply and 8/8 divide sequencer for the sol-1 core.
- Acts as the initiator on the 8-bit ALU's operand/op/carry interface: it drives a, b, op, mode and cf_in, and consumes alu_out and alu_cf_out in the same cycle.
- Performs shift-add multiplication and restoring division, one iteration per clock, so MUL/DIV microcode needs no dedicated adder.

Parameters:
- ITERS, 8, iteration count; equals operand width; fixed at 8 for this core.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- is_div  in  1  0 = multiply, 1 = divide; sampled with start
- op_a  in  8  multiplicand / dividend; sampled with start
- op_b  in  8  multiplier / divisor; sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when results are valid
- result_lo  out  8  product low byte / quotient
- result_hi  out  8  product high byte / remainder
- div_by_zero  out  1  set with done when is_div and op_b == 0
- alu_a  out  8  to ALU a
- alu_b  out  8  to ALU b
- alu_op  out  4  to ALU op
- alu_mode  out  1  to ALU mode
- alu_cf_in  out  1  to ALU cf_in
- alu_res  in  8  from ALU alu_out (combinational, same cycle)
- alu_cf  in  1  from ALU alu_cf_out

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; all registers and outputs = 0.
  - ALU drive = pass-A idle encoding.
- Idle ALU drive: alu_op=4'b1111, alu_mode=1, alu_cf_in=0, alu_a=alu_b=0.
- States: IDLE -> ITER -> DONE -> IDLE.
- IDLE:
  - On start: latch is_div, op_b (into D), and init registers; cnt=0.
  - MUL: H=0, L=op_a.
  - DIV: R=0, Q=op_a.
  - DIV with op_b==0: go to DONE directly; result_lo=8'hFF, result_hi=op_a, div_by_zero=1.
  - Otherwise go to ITER.
- ITER, MUL (add with carry, carry-in inactive):
  - Drive alu_op=4'b1001, alu_mode=0, alu_cf_in=1, alu_a=H, alu_b = L[0] ? D : 8'h00.
  - True carry c = ~alu_cf (ALU carry out is active-low for add).
  - Update {H,L} <= {c, alu_res, L[7:1]}.
- ITER, DIV (subtract, borrow-in inactive):
  - Form S = {R[6:0],Q[7]}; drive alu_op=4'b0110, alu_mode=0, alu_cf_in=0, alu_a=S, alu_b=D.
  - Borrow is alu_cf (1 = S<D).
  - If R[7]==1 or alu_cf==0: R<=alu_res, Q<={Q[6:0],1}.
  - Else: R<=S, Q<={Q[6:0],0}.
- ITER counting: cnt increments each ITER cycle; after the 8th ITER cycle (cnt==7) go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - Load result_lo/result_hi: MUL {H,L} -> hi,lo; DIV Q -> lo, R -> hi.
  - Next state IDLE.
- Latency: start sampled at edge N; done high in cycle N+9, or N+1 for div-by-zero.
- Result outputs hold their values until the next DONE. div_by_zero holds until the next start is accepted (cleared at acceptance).
- start while busy (ITER or DONE) is ignored, with no queuing; is_div, op_a and op_b changes while busy have no effect.
- start in the same cycle as DONE is ignored; earliest new acceptance is the first IDLE cycle.
- Reset mid-operation: immediate return to IDLE; outputs cleared; no done pulse.
- Outside ITER, the ALU is driven with the idle encoding; alu_res/alu_cf are ignored.

Test Plan:
- MUL 0xFF x 0xFF with the real ALU instance -> done at start+9; result_hi=0xFE, result_lo=0x01; during ITER alu_op=4'b1001, mode=0, cf_in=1.
- DIV 200 / 7 (0xC8 / 0x07) -> result_lo=0x1C, result_hi=0x04, div_by_zero=0; during ITER alu_op=4'b0110, mode=0, cf_in=0.
- Boundaries: DIV 0xFF/0x01 -> 0xFF r 0x00. DIV 0x05/0x09 -> 0x00 r 0x05. MUL 0x00 x 0xA5 -> 0x0000. DIV 0x80/0x80 -> 0x01 r 0x00.
- DIV 0x37 / 0x00 -> done at start+1; result_lo=0xFF, result_hi=0x37, div_by_zero=1. Next MUL 3 x 4 -> div_by_zero=0, result 0x000C.
- start pulsed at cycles 3 and 9 of a running MUL 0x10 x 0x10 -> single done; result 0x0100. Back-to-back start held high -> new acceptance one cycle after the done cycle.
- rst_n asserted asynchronously at ITER cycle 4 -> outputs 0, busy=0 immediately; no done. After release, DIV 0x64/0x0A -> 0x0A r 0x00.
